// File: rtl/delay_line.sv
// Runtime-programmable delay line with per-sample valid, stall, flush and fill tracking.
// Optional zero-latency bypass for delay_sel == 0 is enabled by defining DELAY_LINE_BYPASS_EN.
module delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [SW-1:0]    delay_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             primed,
    output logic [SW-1:0]    sel_cur
);

    localparam logic [SW-1:0] DEPTH_SW = SW'(DEPTH);
`ifdef DELAY_LINE_BYPASS_EN
    localparam logic [SW-1:0] SEL_ZERO = '0;
`else
    localparam logic [SW-1:0] SEL_ZERO = SW'(1);
`endif

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [SW-1:0]    fill_q, fill_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    sel_eff;
    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;
    logic             bypass;

    always_comb begin
        sel_eff = delay_sel;
        if (delay_sel > DEPTH_SW) begin
            sel_eff = DEPTH_SW;
        end else if (delay_sel == '0) begin
            sel_eff = SEL_ZERO;
        end
    end

    // A latency change is treated exactly like a flush so samples never duplicate or reorder.
    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        fill_d  = fill_q;
        sel_d   = sel_q;
        if (flush || (sel_eff != sel_q)) begin
            vld_d  = '0;
            fill_d = '0;
            sel_d  = sel_eff;
        end else if (en) begin
            stage_d[0] = din;
            vld_d[0]   = din_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
            if (fill_q != DEPTH_SW) begin
                fill_d = fill_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
            sel_q  <= SW'(1);
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            fill_q  <= fill_d;
            sel_q   <= sel_d;
        end
    end

    // Output tap is stage[sel_q-1]; purely a mux over registers.
    always_comb begin
        tap_data = '0;
        tap_vld  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_q == SW'(i + 1)) begin
                tap_data = stage_q[i];
                tap_vld  = vld_q[i];
            end
        end
    end

`ifdef DELAY_LINE_BYPASS_EN
    assign bypass = (sel_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign dout_valid = bypass ? din_valid : tap_vld;
    assign dout       = dout_valid ? (bypass ? din : tap_data) : '0;
    assign primed     = bypass | (fill_q >= sel_q);
    assign sel_cur    = sel_q;

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (WIDTH=16, DEPTH=4).
module tb_delay_line;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic [SW-1:0]    delay_sel;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             primed;
    logic [SW-1:0]    sel_cur;

    int checks = 0;
    int errors = 0;

    delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .delay_sel (delay_sel),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .primed    (primed),
        .sel_cur   (sel_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, and settle 1 time unit after it.
    task automatic tick(input logic e, input logic f, input logic [WIDTH-1:0] d, input logic dv);
        en        = e;
        flush     = f;
        din       = d;
        din_valid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        en        = 1'b1;
        flush     = 1'b0;
        delay_sel = 3'd4;
        din       = '0;
        din_valid = 1'b0;
        #12;
        checks++;
        if (dout !== 16'h0 || dout_valid !== 1'b0 || primed !== 1'b0 || sel_cur !== 3'd1) begin
            errors++;
            $display("[TB] FAIL reset_state dout=%h v=%b p=%b sel=%0d want 0000 0 0 1", dout, dout_valid, primed, sel_cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (sel_cur !== 3'd4 || dout_valid !== 1'b0 || primed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_apply_sel sel=%0d v=%b p=%b want 4 0 0", sel_cur, dout_valid, primed);
        end
        tick(1'b1, 1'b0, 16'h0001, 1'b1);
        tick(1'b1, 1'b0, 16'h0002, 1'b1);
        tick(1'b1, 1'b0, 16'h0003, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || primed !== 1'b0 || dout !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_fill_edge2 dout=%h v=%b p=%b want 0000 0 0", dout, dout_valid, primed);
        end
        tick(1'b1, 1'b0, 16'h0004, 1'b1);
        checks++;
        if (dout !== 16'h0001 || dout_valid !== 1'b1 || primed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_out dout=%h v=%b p=%b want 0001 1 1", dout, dout_valid, primed);
        end
        tick(1'b1, 1'b0, 16'h0005, 1'b1);
        checks++;
        if (dout !== 16'h0002 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_second_out dout=%h v=%b want 0002 1", dout, dout_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 16'h0 || dout_valid !== 1'b0 || primed !== 1'b0 || sel_cur !== 3'd1) begin
            errors++;
            $display("[TB] FAIL reset_async dout=%h v=%b p=%b sel=%0d want 0000 0 0 1", dout, dout_valid, primed, sel_cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stall;
        delay_sel = 3'd2;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h00A0, 1'b1);
        tick(1'b1, 1'b0, 16'h00A1, 1'b1);
        checks++;
        if (dout !== 16'h00A0 || dout_valid !== 1'b1 || primed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_first dout=%h v=%b p=%b want 00a0 1 1", dout, dout_valid, primed);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 16'h00EE, 1'b1);
            checks++;
            if (dout !== 16'h00A0 || dout_valid !== 1'b1 || primed !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d dout=%h v=%b p=%b want 00a0 1 1", i, dout, dout_valid, primed);
            end
        end
        tick(1'b1, 1'b0, 16'h00A2, 1'b1);
        checks++;
        if (dout !== 16'h00A1 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_resume dout=%h v=%b want 00a1 1", dout, dout_valid);
        end
        tick(1'b1, 1'b0, 16'h00A3, 1'b1);
        checks++;
        if (dout !== 16'h00A2) begin
            errors++;
            $display("[TB] FAIL stall_next dout=%h want 00a2", dout);
        end
    endtask

    task automatic test_select_change;
        delay_sel = 3'd4;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h00B0, 1'b1);
        tick(1'b1, 1'b0, 16'h00B1, 1'b1);
        tick(1'b1, 1'b0, 16'h00B2, 1'b1);
        tick(1'b1, 1'b0, 16'h00B3, 1'b1);
        checks++;
        if (dout !== 16'h00B0 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL selchg_pre dout=%h v=%b want 00b0 1", dout, dout_valid);
        end
        delay_sel = 3'd2;
        tick(1'b1, 1'b0, 16'h00B4, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 16'h0 || sel_cur !== 3'd2 || primed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL selchg_edge dout=%h v=%b sel=%0d p=%b want 0000 0 2 0", dout, dout_valid, sel_cur, primed);
        end
        tick(1'b1, 1'b0, 16'h00B5, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 16'h0) begin
            errors++;
            $display("[TB] FAIL selchg_gap dout=%h v=%b want 0000 0", dout, dout_valid);
        end
        tick(1'b1, 1'b0, 16'h00B6, 1'b1);
        checks++;
        if (dout !== 16'h00B5 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL selchg_first dout=%h v=%b want 00b5 1", dout, dout_valid);
        end
        tick(1'b1, 1'b0, 16'h00B7, 1'b1);
        checks++;
        if (dout !== 16'h00B6 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL selchg_second dout=%h v=%b want 00b6 1", dout, dout_valid);
        end
    endtask

    task automatic test_clamp;
        delay_sel = 3'd7;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (sel_cur !== 3'd4) begin
            errors++;
            $display("[TB] FAIL clamp_high_sel sel=%0d want 4", sel_cur);
        end
        tick(1'b1, 1'b0, 16'h00C0, 1'b1);
        tick(1'b1, 1'b0, 16'h00C1, 1'b1);
        tick(1'b1, 1'b0, 16'h00C2, 1'b1);
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_high_early v=%b want 0", dout_valid);
        end
        tick(1'b1, 1'b0, 16'h00C3, 1'b1);
        checks++;
        if (dout !== 16'h00C0 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clamp_high_out dout=%h v=%b want 00c0 1", dout, dout_valid);
        end
`ifndef DELAY_LINE_BYPASS_EN
        delay_sel = 3'd0;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (sel_cur !== 3'd1) begin
            errors++;
            $display("[TB] FAIL clamp_zero_sel sel=%0d want 1", sel_cur);
        end
        tick(1'b1, 1'b0, 16'h00D0, 1'b1);
        checks++;
        if (dout !== 16'h00D0 || dout_valid !== 1'b1 || primed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clamp_zero_out dout=%h v=%b p=%b want 00d0 1 1", dout, dout_valid, primed);
        end
`endif
    endtask

    task automatic test_flush_bubble;
        delay_sel = 3'd2;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h00E0, 1'b1);
        tick(1'b1, 1'b0, 16'h00E1, 1'b1);
        checks++;
        if (dout !== 16'h00E0 || primed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_pre dout=%h p=%b want 00e0 1", dout, primed);
        end
        tick(1'b1, 1'b1, 16'h0055, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 16'h0 || primed !== 1'b0 || sel_cur !== 3'd2) begin
            errors++;
            $display("[TB] FAIL flush_edge dout=%h v=%b p=%b sel=%0d want 0000 0 0 2", dout, dout_valid, primed, sel_cur);
        end
        tick(1'b1, 1'b0, 16'h00E3, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 16'h0) begin
            errors++;
            $display("[TB] FAIL flush_no55 dout=%h v=%b want 0000 0", dout, dout_valid);
        end
        tick(1'b1, 1'b0, 16'h00FF, 1'b0);
        checks++;
        if (dout !== 16'h00E3 || dout_valid !== 1'b1 || primed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_after dout=%h v=%b p=%b want 00e3 1 1", dout, dout_valid, primed);
        end
        tick(1'b1, 1'b0, 16'h00E5, 1'b1);
        checks++;
        if (dout !== 16'h0 || dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bubble_out dout=%h v=%b want 0000 0", dout, dout_valid);
        end
        tick(1'b1, 1'b0, 16'h00E6, 1'b1);
        checks++;
        if (dout !== 16'h00E5 || dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bubble_after dout=%h v=%b want 00e5 1", dout, dout_valid);
        end
    endtask

`ifdef DELAY_LINE_BYPASS_EN
    task automatic test_bypass;
        delay_sel = 3'd0;
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (sel_cur !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bypass_sel sel=%0d want 0", sel_cur);
        end
        en        = 1'b0;
        din       = 16'h1234;
        din_valid = 1'b1;
        #1;
        checks++;
        if (dout !== 16'h1234 || dout_valid !== 1'b1 || primed !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bypass_pass dout=%h v=%b p=%b want 1234 1 1", dout, dout_valid, primed);
        end
        din_valid = 1'b0;
        #1;
        checks++;
        if (dout !== 16'h0 || dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass_invalid dout=%h v=%b want 0000 0", dout, dout_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_select_change();
        test_clamp();
        test_flush_bubble();
`ifdef DELAY_LINE_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
